// File: rtl/lcd_panel_responder.sv
// Panel end of an HD44780-style LCD bus: decodes e/rs/rw strobes and holds DDRAM, AC, mode flags and the busy flag.
// Optional LCD_BUSY_CHECK_EN enables the sticky protocol_err flag; when it is undefined, protocol_err is tied low.
module lcd_panel_responder #(
  parameter int unsigned CLK_FREQ    = 15,
  parameter int unsigned DDRAM_DEPTH = 80,
  parameter int unsigned T_POWERUP   = 400,
  parameter int unsigned T_EXEC      = 37,
  parameter int unsigned T_CLEAR     = 152
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  output logic       busy_flag,
  output logic [6:0] addr_counter,
  output logic [6:0] display_offset,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_dec,
  output logic       entry_shift,
  output logic       lines_2,
  output logic       font_5x10,
  output logic       protocol_err
);

  localparam int unsigned PWR_CYC = T_POWERUP * CLK_FREQ;
  localparam int unsigned EXEC_CYC = T_EXEC * CLK_FREQ;
  localparam int unsigned CLR_CYC = T_CLEAR * CLK_FREQ;
  localparam int unsigned MAX_A = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > EXEC_CYC) ? MAX_A : EXEC_CYC;
  localparam int unsigned CW = $clog2(MAX_CYC + 1);
  localparam logic [6:0] LAST = 7'(DDRAM_DEPTH - 1);

  // AC and display offset wrap at the ends of the DDRAM address range.
  function automatic logic [6:0] step_wrap(input logic [6:0] v, input logic up);
    if (up) return (v == LAST) ? 7'd0 : v + 7'd1;
    else    return (v == 7'd0) ? LAST : v - 7'd1;
  endfunction

  logic          r_e_d;
  logic          r_rs;
  logic          r_rw;
  logic [7:0]    r_data;
  logic [CW-1:0] r_busy_cnt;
  logic [6:0]    r_ac;
  logic [6:0]    r_offset;
  logic          r_disp_on, r_cursor_on, r_blink_on;
  logic          r_inc_dec, r_entry_shift, r_lines_2, r_font_5x10;
  logic          r_fill_active;
  logic [6:0]    r_fill_addr;
  logic [7:0]    r_ddram [DDRAM_DEPTH];

  logic w_commit;
  logic w_busy;
  logic w_wr_ok;
  logic w_data_wr;

  assign w_commit  = r_e_d & ~e;
  assign w_busy    = (r_busy_cnt != '0);
  assign w_wr_ok   = w_commit & ~r_rw & ~w_busy;
  assign w_data_wr = w_wr_ok & r_rs;

  // Last values seen while e was high are what the falling edge commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_e_d  <= 1'b0;
      r_rs   <= 1'b0;
      r_rw   <= 1'b0;
      r_data <= 8'h00;
    end else begin
      r_e_d <= e;
      if (e) begin
        r_rs   <= rs;
        r_rw   <= rw;
        r_data <= lcd_data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_cnt    <= CW'(PWR_CYC);
      r_ac          <= 7'd0;
      r_offset      <= 7'd0;
      r_disp_on     <= 1'b0;
      r_cursor_on   <= 1'b0;
      r_blink_on    <= 1'b0;
      r_inc_dec     <= 1'b0;
      r_entry_shift <= 1'b0;
      r_lines_2     <= 1'b0;
      r_font_5x10   <= 1'b0;
      r_fill_active <= 1'b0;
      r_fill_addr   <= 7'd0;
    end else begin
      if (r_fill_active) begin
        if (r_fill_addr == LAST) r_fill_active <= 1'b0;
        r_fill_addr <= r_fill_addr + 7'd1;
      end
      if (w_busy) r_busy_cnt <= r_busy_cnt - CW'(1);
      if (w_wr_ok) begin
        r_busy_cnt <= CW'(EXEC_CYC);
        if (r_rs) begin
          r_ac <= step_wrap(r_ac, r_inc_dec);
          if (r_entry_shift) r_offset <= step_wrap(r_offset, r_inc_dec);
        end else begin
          casez (r_data)
            8'b1???????: r_ac <= (r_data[6:0] >= 7'(DDRAM_DEPTH)) ? 7'd0 : r_data[6:0];
            8'b01??????: begin end
            8'b001?????: begin
              r_lines_2   <= r_data[3];
              r_font_5x10 <= r_data[2];
            end
            8'b0001????: begin
              if (r_data[3]) r_offset <= step_wrap(r_offset, r_data[2]);
              else           r_ac     <= step_wrap(r_ac, r_data[2]);
            end
            8'b00001???: begin
              r_disp_on   <= r_data[2];
              r_cursor_on <= r_data[1];
              r_blink_on  <= r_data[0];
            end
            8'b000001??: begin
              r_inc_dec     <= r_data[1];
              r_entry_shift <= r_data[0];
            end
            8'b0000001?: begin
              r_ac     <= 7'd0;
              r_offset <= 7'd0;
            end
            8'b00000001: begin
              r_busy_cnt    <= CW'(CLR_CYC);
              r_ac          <= 7'd0;
              r_offset      <= 7'd0;
              r_inc_dec     <= 1'b1;
              r_fill_active <= 1'b1;
              r_fill_addr   <= 7'd0;
            end
            default: begin end
          endcase
        end
      end else if (w_commit && r_rw && r_rs) begin
        r_ac <= step_wrap(r_ac, r_inc_dec);
      end
    end
  end

  // DDRAM survives reset; the clear fill runs under busy, so it never collides with a data write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_data_wr)          r_ddram[r_ac]        <= r_data;
      else if (r_fill_active) r_ddram[r_fill_addr] <= 8'h20;
    end
  end

  assign lcd_data_oe = r_e_d & r_rw;

  always_comb begin
    lcd_data_out = 8'h00;
    if (lcd_data_oe) lcd_data_out = r_rs ? r_ddram[r_ac] : {w_busy, r_ac};
  end

`ifdef LCD_BUSY_CHECK_EN
  logic r_perr;
  // e is sampled on clk, so a pulse shorter than one cycle is never captured and cannot be flagged.
  always_ff @(posedge clk) begin
    if (rst)                              r_perr <= 1'b0;
    else if (w_commit && !r_rw && w_busy) r_perr <= 1'b1;
  end
  assign protocol_err = r_perr;
`else
  assign protocol_err = 1'b0;
`endif

  assign busy_flag      = w_busy;
  assign addr_counter   = r_ac;
  assign display_offset = r_offset;
  assign disp_on        = r_disp_on;
  assign cursor_on      = r_cursor_on;
  assign blink_on       = r_blink_on;
  assign inc_dec        = r_inc_dec;
  assign entry_shift    = r_entry_shift;
  assign lines_2        = r_lines_2;
  assign font_5x10      = r_font_5x10;

endmodule

// File: tb/tb_lcd_panel_responder.sv
// Bench for lcd_panel_responder: directed bring-up then random bus traffic against a behavioural panel model.
// Expected protocol_err follows LCD_BUSY_CHECK_EN when the bench is built with the same define as the RTL.
module tb_lcd_panel_responder;

  logic       clk = 1'b0;
  logic       rst, e, rs, rw;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe, busy_flag;
  logic [6:0] addr_counter, display_offset;
  logic       disp_on, cursor_on, blink_on, inc_dec, entry_shift, lines_2, font_5x10;
  logic       protocol_err;

  lcd_panel_responder dut (
    .clk(clk), .rst(rst), .e(e), .rs(rs), .rw(rw), .lcd_data_in(lcd_data_in),
    .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe), .busy_flag(busy_flag),
    .addr_counter(addr_counter), .display_offset(display_offset),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on), .inc_dec(inc_dec),
    .entry_shift(entry_shift), .lines_2(lines_2), .font_5x10(font_5x10),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Panel model: timing is an absolute cycle at which busy ends.
  logic [7:0] mMem [80];
  bit         mKnown [80];
  int         mAc, mOff, busyEnd;
  bit         mDisp, mCursor, mBlink, mInc, mEntry, mLines, mFont, mErr;
  int         passCount = 0;
  int         checkCount = 0;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checkCount++;
    if (got == exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cycle);
  endtask

  function automatic int wrap(input int v);
    return (v + 80) % 80;
  endfunction

  function automatic int flagsModel();
    return {mDisp, mCursor, mBlink, mInc, mEntry, mLines, mFont};
  endfunction

  task automatic checkState(input string tag);
    checkOutput({tag, "_ac"}, addr_counter, mAc);
    checkOutput({tag, "_offset"}, display_offset, mOff);
    checkOutput({tag, "_flags"}, {disp_on, cursor_on, blink_on, inc_dec, entry_shift, lines_2, font_5x10},
                flagsModel());
    checkOutput({tag, "_busy"}, busy_flag, (cycle < busyEnd) ? 1 : 0);
    checkOutput({tag, "_perr"}, protocol_err, mErr);
  endtask

  task automatic applyReset();
    rst = 1'b1; e = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    busyEnd = cycle + 6000;
    mAc = 0; mOff = 0; mErr = 0;
    {mDisp, mCursor, mBlink, mInc, mEntry, mLines, mFont} = '0;
  endtask

  // Write committed at edge c; the flag the panel sees then reflects edge c-1.
  task automatic modelWrite(input bit isData, input logic [7:0] d, input int c);
    int dir;
    if (c <= busyEnd) begin
`ifdef LCD_BUSY_CHECK_EN
      mErr = 1;
`endif
      return;
    end
    busyEnd = c + 555;
    if (isData) begin
      mMem[mAc] = d; mKnown[mAc] = 1;
      dir = mInc ? 1 : -1;
      if (mEntry) mOff = wrap(mOff + dir);
      mAc = wrap(mAc + dir);
    end else if (d >= 128) begin
      mAc = (int'(d) - 128 < 80) ? int'(d) - 128 : 0;
    end else if (d >= 64) begin
    end else if (d >= 32) begin
      mLines = d[3]; mFont = d[2];
    end else if (d >= 16) begin
      dir = d[2] ? 1 : -1;
      if (d[3]) mOff = wrap(mOff + dir);
      else      mAc = wrap(mAc + dir);
    end else if (d >= 8) begin
      mDisp = d[2]; mCursor = d[1]; mBlink = d[0];
    end else if (d >= 4) begin
      mInc = d[1]; mEntry = d[0];
    end else if (d >= 2) begin
      mAc = 0; mOff = 0;
    end else if (d == 1) begin
      mAc = 0; mOff = 0; mInc = 1;
      for (int i = 0; i < 80; i++) begin mMem[i] = 8'h20; mKnown[i] = 1; end
      busyEnd = c + 2280;
    end
  endtask

  task automatic busWrite(input bit isData, input logic [7:0] d);
    e = 1'b1; rs = isData; rw = 1'b0; lcd_data_in = d;
    @(negedge clk);
    e = 1'b0; lcd_data_in = 8'($urandom);
    @(negedge clk);
    modelWrite(isData, d, cycle);
  endtask

  task automatic busRead(input bit isData);
    e = 1'b1; rs = isData; rw = 1'b1; lcd_data_in = 8'($urandom);
    @(negedge clk);
    checkOutput("read_oe", lcd_data_oe, 1);
    if (isData) begin
      if (mKnown[mAc]) checkOutput("read_ddram", lcd_data_out, mMem[mAc]);
    end else begin
      checkOutput("read_bf_ac", lcd_data_out, ((cycle < busyEnd) ? 128 : 0) + mAc);
    end
    e = 1'b0;
    @(negedge clk);
    if (isData) mAc = wrap(mAc + (mInc ? 1 : -1));
    checkOutput("read_oe_release", lcd_data_oe, 0);
  endtask

  task automatic waitReady(input string tag);
    if (cycle < busyEnd) begin
      while (cycle < busyEnd - 1) @(negedge clk);
      checkOutput({tag, "_busy_last"}, busy_flag, 1);
      @(negedge clk);
      checkOutput({tag, "_busy_done"}, busy_flag, 0);
    end
  endtask

  task automatic applyStimulus(input int op);
    logic [7:0] d;
    d = 8'($urandom);
    case (op)
      0, 5: begin waitReady("rnd_wd"); busWrite(1'b1, d); end
      1: begin waitReady("rnd_wi"); busWrite(1'b0, (d == 8'h01) ? 8'h00 : d); end
      2: begin waitReady("rnd_rd"); busRead(1'b1); end
      3: busRead(1'b0);
      default: busWrite(1'b0, (d == 8'h01) ? 8'h0C : d);
    endcase
  endtask

  initial begin
    rst = 1'b1; e = 1'b0; rs = 1'b0; rw = 1'b0; lcd_data_in = 8'h00;
    applyReset();
    checkState("reset");
    checkOutput("reset_oe", lcd_data_oe, 0);
    checkOutput("reset_out", lcd_data_out, 0);
    busRead(1'b0);
    waitReady("powerup");
    busRead(1'b0);

    busWrite(1'b0, 8'h38); waitReady("fnset");
    busWrite(1'b0, 8'h0E); waitReady("dispctl");
    checkState("modes");

    busWrite(1'b0, 8'h01); waitReady("clear");
    for (int i = 0; i < 80; i++) busRead(1'b1);
    checkState("clear_readback");

    busWrite(1'b0, 8'h80); waitReady("addr0");
    busWrite(1'b1, 8'h41); waitReady("wr41");
    busWrite(1'b0, 8'h80); waitReady("addr0b");
    busRead(1'b1);
    checkState("rd41");

    busWrite(1'b0, 8'hCF); waitReady("addr79");
    busWrite(1'b1, 8'($urandom)); waitReady("wr79");
    checkState("wrap_up");
    busWrite(1'b0, 8'h04); waitReady("entry_dec");
    busWrite(1'b1, 8'($urandom)); waitReady("wr0");
    checkState("wrap_down");

    busWrite(1'b0, 8'h00);
    busWrite(1'b0, 8'h0C);
    checkState("busy_write");
    waitReady("busy_write");

    busWrite(1'b0, 8'h07); waitReady("entry_shift");
    busWrite(1'b1, 8'h55); waitReady("shift_wr");
    checkState("entry_shift");

    for (int n = 0; n < 60; n++) begin
      applyStimulus(int'($urandom_range(0, 6)));
      checkState("rnd");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: bench did not finish, cycle %0d", cycle);
    $fatal(1, "[TB] timeout");
  end

endmodule
